// File: rtl/ysyx_25040109_lsu.sv
// ysyx_25040109_lsu: load/store stage between execute and writeback.
// Loads and stores go through a single-outstanding request/response port.
// The port uses byte-lane masking, and loads are sign- or zero-extended.
// Non-memory instructions pass through with one cycle of latency.
// Optional macro LSU_MISALIGN_CHECK_EN turns misaligned H/W accesses into
// access faults that never reach the memory port.
module ysyx_25040109_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_funct3,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_reg_write,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_wb_data,
  output logic [4:0]  out_rd_addr,
  output logic        out_reg_write,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [15:0] TERM_COUNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] count;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic        reg_write_q;
  logic        accept, is_mem, bad_funct3, misalign, timeout;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_data;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;

  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign out_valid     = (state == DONE);
  assign accept        = in_valid && in_ready;
  assign is_mem        = in_is_load || in_is_store;
  assign bad_funct3    = in_is_load && (in_funct3 == 3'b011 || in_funct3[2:1] == 2'b11);
  assign timeout       = (count == TERM_COUNT);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = (in_funct3[1:0] == 2'b01 && in_result[0]) ||
                    (in_funct3[1] && in_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (!is_mem || bad_funct3 || misalign) state_next = DONE;
        else                                   state_next = REQ;
      end
      REQ:  if (mem_req_ready) state_next = WAIT;
      WAIT: if (mem_resp_valid || timeout) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store lane placement from size and low address bits
  always_comb begin
    st_wmask = 4'b1111;
    st_wdata = in_wdata;
    case (in_funct3[1:0])
      2'b00: begin
        st_wmask = 4'b0001 << in_result[1:0];
        st_wdata = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        st_wmask = in_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and extension
  always_comb begin
    case (lane_q)
      2'd0:    rbyte = mem_resp_rdata[7:0];
      2'd1:    rbyte = mem_resp_rdata[15:8];
      2'd2:    rbyte = mem_resp_rdata[23:16];
      default: rbyte = mem_resp_rdata[31:24];
    endcase
    rhalf = lane_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_data = {24'b0, rbyte};
      3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
      3'b101:  load_data = {16'b0, rhalf};
      default: load_data = mem_resp_rdata;
    endcase
  end

  // Request latching, timeout counter and writeback result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      out_wb_data   <= '0;
      out_rd_addr   <= '0;
      out_reg_write <= 1'b0;
      out_err       <= 1'b0;
      count         <= '0;
      funct3_q      <= '0;
      lane_q        <= '0;
      reg_write_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          out_rd_addr <= in_rd_addr;
          out_err     <= 1'b0;
          if (!is_mem) begin
            out_wb_data   <= in_result;
            out_reg_write <= in_reg_write;
          end else if (bad_funct3) begin
            out_wb_data   <= '0;
            out_reg_write <= 1'b0;
          end else if (misalign) begin
            out_wb_data   <= in_result;
            out_reg_write <= 1'b0;
            out_err       <= 1'b1;
          end else begin
            // load wins when both opcode flags are set
            mem_req_wen   <= !in_is_load;
            mem_req_addr  <= {in_result[31:2], 2'b00};
            mem_req_wdata <= st_wdata;
            mem_req_wmask <= in_is_load ? 4'b0000 : st_wmask;
            funct3_q      <= in_funct3;
            lane_q        <= in_result[1:0];
            reg_write_q   <= in_reg_write;
          end
        end
        REQ: if (mem_req_ready) count <= '0;
        WAIT: begin
          count <= count + 16'd1;
          // a response on the terminal count takes priority over the timeout
          if (mem_resp_valid) begin
            out_wb_data   <= mem_req_wen ? 32'd0 : load_data;
            out_reg_write <= mem_req_wen ? 1'b0 : reg_write_q;
          end else if (timeout) begin
            out_wb_data   <= '0;
            out_reg_write <= 1'b0;
            out_err       <= 1'b1;
          end
        end
        DONE: if (out_ready) out_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
`timescale 1ns/1ps
module tb_ysyx_25040109_lsu;
  localparam int unsigned TMO = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_result = 0, in_wdata = 0;
  logic [2:0]  in_funct3 = 0;
  logic        in_is_load = 0, in_is_store = 0;
  logic [4:0]  in_rd_addr = 0;
  logic        in_reg_write = 0;
  logic        mem_req_valid, mem_req_ready = 0, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid = 0;
  logic [31:0] mem_resp_rdata = 0;
  logic        out_valid, out_ready = 0;
  logic [31:0] out_wb_data;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write, out_err;

  always #5 clk = ~clk;

  ysyx_25040109_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_wdata(in_wdata),
    .in_funct3(in_funct3), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_wb_data(out_wb_data),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write), .out_err(out_err)
  );

  int checks = 0, failures = 0;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw;
    logic        err;
  } exp_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw;
    logic        err;
    logic        stable;
    logic        held;
    logic        tmo;
    int          n_first;
    int          n_wait;
  } obs_t;

  typedef struct {
    logic [31:0] res, wd, rdata;
    logic [2:0]  f3;
    logic        ld, st;
    logic [4:0]  rd;
    logic        rw;
    int          stall, lat, bp;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] res, wd, rdata, input logic [2:0] f3,
                               input logic ld, st, input logic [4:0] rd, input logic rw,
                               input int stall, lat, bp, input logic req,
                               input logic [31:0] addr, input logic wen, input logic [3:0] wmask,
                               input logic [31:0] wdata, wb, input logic erw, err);
    vec_t v;
    v.res = res; v.wd = wd; v.rdata = rdata; v.f3 = f3; v.ld = ld; v.st = st;
    v.rd = rd; v.rw = rw; v.stall = stall; v.lat = lat; v.bp = bp;
    v.e.req = req; v.e.addr = addr; v.e.wen = wen; v.e.wmask = wmask; v.e.wdata = wdata;
    v.e.wb = wb; v.e.rd = rd; v.e.rw = erw; v.e.err = err;
    return v;
  endfunction

  // Reference model derived from the size/lane/extension rules with plain arithmetic
  function automatic exp_t model(input logic [31:0] res, wd, rdata, input logic [2:0] f3,
                                 input logic ld, st, input logic [4:0] rd, input logic rw);
    exp_t e;
    int unsigned a, size, off;
    logic [31:0] v, sgn;
    e = '{default: 0};
    e.rd = rd;
    if (!ld && !st) begin e.wb = res; e.rw = rw; return e; end
    if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return e;
    a = res % 4;
    size = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
`ifdef LSU_MISALIGN_CHECK_EN
    if (res % size != 0) begin e.err = 1; e.wb = res; return e; end
`endif
    e.req = 1;
    e.addr = res - a;
    e.wen = st && !ld;
    if (e.wen) begin
      if (size == 1)      begin e.wmask = 4'(1 << a);       e.wdata = (wd & 32'hFF) * 32'h01010101; end
      else if (size == 2) begin e.wmask = 4'(3 << (a & 2)); e.wdata = (wd & 32'hFFFF) * 32'h00010001; end
      else                begin e.wmask = 4'hF;             e.wdata = wd; end
    end else begin
      off = (size == 1) ? a : (size == 2) ? (a & 2) : 0;
      v = rdata >> (8 * off);
      sgn = 0;
      if (size == 1) begin v = v & 32'hFF;   sgn = 32'h80;   end
      if (size == 2) begin v = v & 32'hFFFF; sgn = 32'h8000; end
      if (!f3[2] && size < 4 && v >= sgn) v = v - 2 * sgn;
      e.wb = v;
      e.rw = rw;
    end
    return e;
  endfunction

  task automatic run_op(input logic [31:0] res, wd, rdata, input logic [2:0] f3,
                        input logic ld, st, input logic [4:0] rd, input logic rw,
                        input int stall, lat, bp, output obs_t o);
    int n;
    o = '{default: 0};
    o.stable = 1; o.held = 1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    in_result = res; in_wdata = wd; in_funct3 = f3; in_is_load = ld; in_is_store = st;
    in_rd_addr = rd; in_reg_write = rw; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in_is_load = 0; in_is_store = 0; in_result = $urandom; in_wdata = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req_valid && !out_valid && n < 40);
    o.n_first = n;
    if (mem_req_valid) begin
      o.req = 1; o.addr = mem_req_addr; o.wen = mem_req_wen;
      o.wmask = mem_req_wmask; o.wdata = mem_req_wdata;
      for (int s = 0; s < stall; s++) begin
        mem_req_ready = 0;
        @(negedge clk);
        if (!mem_req_valid || mem_req_addr !== o.addr || mem_req_wen !== o.wen ||
            mem_req_wmask !== o.wmask || mem_req_wdata !== o.wdata) o.stable = 0;
      end
      mem_req_ready = 1;
      @(posedge clk); #1;
      mem_req_ready = 0;
      if (lat >= 0) begin
        if (lat > 0) begin repeat (lat) @(posedge clk); #1; end
        mem_resp_valid = 1; mem_resp_rdata = rdata;
        @(posedge clk); #1;
        mem_resp_valid = 0; mem_resp_rdata = $urandom;
      end
      n = 0;
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      o.n_wait = n;
    end
    if (!out_valid) begin o.tmo = 1; return; end
    o.wb = out_wb_data; o.rd = out_rd_addr; o.rw = out_reg_write; o.err = out_err;
    for (int b = 0; b < bp; b++) begin
      out_ready = 0;
      @(negedge clk);
      if (!out_valid || in_ready || out_wb_data !== o.wb || out_rd_addr !== o.rd ||
          out_reg_write !== o.rw || out_err !== o.err) o.held = 0;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic cmp(input string tag, input obs_t o, input exp_t e, input int bp);
    chk({tag, "_no_hang"}, o.tmo, 0);
    chk({tag, "_req"}, o.req, e.req);
    if (e.req && o.req) begin
      chk({tag, "_addr"}, o.addr, e.addr);
      chk({tag, "_wen"}, o.wen, e.wen);
      chk({tag, "_wmask"}, o.wmask, e.wmask);
      chk({tag, "_req_stable"}, o.stable, 1);
      if (e.wen) chk({tag, "_wdata"}, o.wdata, e.wdata);
    end
    chk({tag, "_wb"}, o.wb, e.wb);
    chk({tag, "_rd"}, o.rd, e.rd);
    chk({tag, "_rw"}, o.rw, e.rw);
    chk({tag, "_err"}, o.err, e.err);
    if (bp > 0) chk({tag, "_held"}, o.held, 1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    obs_t o;
    exp_t e;
    logic ok;
    logic [2:0] f3;
    logic ld, st;
    int kind;

    tbl[0]  = mkv(32'h1234, 0, 0, 3'b000, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 1, 0);
    tbl[1]  = mkv(32'h80000003, 0, 32'h80FF7F01, 3'b000, 1, 0, 7, 1, 0, 1, 0,
                  1, 32'h80000000, 0, 4'h0, 0, 32'hFFFFFF80, 1, 0);
    tbl[2]  = mkv(32'h80000003, 0, 32'h80FF7F01, 3'b100, 1, 0, 7, 1, 1, 0, 0,
                  1, 32'h80000000, 0, 4'h0, 0, 32'h00000080, 1, 0);
    tbl[3]  = mkv(32'h2002, 0, 32'h80FF7F01, 3'b001, 1, 0, 8, 1, 0, 2, 0,
                  1, 32'h2000, 0, 4'h0, 0, 32'hFFFF80FF, 1, 0);
    tbl[4]  = mkv(32'h2000, 0, 32'h80FF7F01, 3'b101, 1, 0, 8, 1, 0, 0, 0,
                  1, 32'h2000, 0, 4'h0, 0, 32'h00007F01, 1, 0);
    tbl[5]  = mkv(32'h3000, 0, 32'hDEADBEEF, 3'b010, 1, 0, 9, 1, 0, 3, 5,
                  1, 32'h3000, 0, 4'h0, 0, 32'hDEADBEEF, 1, 0);
    tbl[6]  = mkv(32'h41, 32'h123456AB, 0, 3'b000, 0, 1, 3, 1, 0, 0, 0,
                  1, 32'h40, 1, 4'b0010, 32'hABABABAB, 0, 0, 0);
    tbl[7]  = mkv(32'h10000002, 32'h0000BEEF, 0, 3'b001, 0, 1, 3, 1, 3, 1, 0,
                  1, 32'h10000000, 1, 4'b1100, 32'hBEEFBEEF, 0, 0, 0);
    tbl[8]  = mkv(32'h50, 32'hCAFEF00D, 0, 3'b010, 0, 1, 3, 1, 0, 0, 0,
                  1, 32'h50, 1, 4'b1111, 32'hCAFEF00D, 0, 0, 0);
    tbl[9]  = mkv(32'h60, 0, 0, 3'b011, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mkv(32'h71, 32'h99, 32'h0000AA00, 3'b000, 1, 1, 6, 1, 0, 0, 0,
                  1, 32'h70, 0, 4'h0, 0, 32'hFFFFFFAA, 1, 0);
    tbl[11] = mkv(32'hA5A5, 0, 0, 3'b000, 0, 0, 31, 0, 0, 0, 5, 0, 0, 0, 0, 0, 32'hA5A5, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    tbl[12] = mkv(32'h102, 0, 32'h11223344, 3'b010, 1, 0, 2, 1, 0, 0, 0,
                  0, 0, 0, 0, 0, 32'h102, 0, 1);
    tbl[13] = mkv(32'h203, 32'h1234, 0, 3'b001, 0, 1, 2, 1, 0, 0, 0,
                  0, 0, 0, 0, 0, 32'h203, 0, 1);
`else
    tbl[12] = mkv(32'h102, 0, 32'h11223344, 3'b010, 1, 0, 2, 1, 0, 0, 0,
                  1, 32'h100, 0, 4'h0, 0, 32'h11223344, 1, 0);
    tbl[13] = mkv(32'h203, 32'h1234, 0, 3'b001, 0, 1, 2, 1, 0, 0, 0,
                  1, 32'h200, 1, 4'b1100, 32'h12341234, 0, 0, 0);
`endif

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", out_err, 0);
    chk("rst_wb", out_wb_data, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_misc", {mem_req_wen, mem_req_wmask, out_rd_addr, out_reg_write}, 0);
    rst_n = 1;

    // directed vectors
    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].res, tbl[i].wd, tbl[i].rdata, tbl[i].f3, tbl[i].ld, tbl[i].st,
             tbl[i].rd, tbl[i].rw, tbl[i].stall, tbl[i].lat, tbl[i].bp, o);
      cmp($sformatf("vec%0d", i), o, tbl[i].e, tbl[i].bp);
      if (i == 0) chk("pass_latency", o.n_first, 1);
    end

    // timeout: no response, DONE follows the 4th WAIT cycle
    run_op(32'h400, 0, 0, 3'b010, 1, 0, 9, 1, 0, -1, 0, o);
    chk("tmo_no_hang", o.tmo, 0);
    chk("tmo_err", o.err, 1);
    chk("tmo_rw", o.rw, 0);
    chk("tmo_cycles", o.n_wait, 5);
    // response on the terminal WAIT cycle wins
    run_op(32'h404, 0, 32'h5A5A0001, 3'b010, 1, 0, 9, 1, 1, 3, 0, o);
    chk("term_err", o.err, 0);
    chk("term_wb", o.wb, 32'h5A5A0001);
    chk("term_rw", o.rw, 1);
    // timeout path leaves the unit usable
    run_op(32'h888, 0, 0, 3'b000, 0, 0, 1, 1, 0, 0, 0, o);
    chk("after_tmo_wb", o.wb, 32'h888);
    chk("after_tmo_err", o.err, 0);

    // reset asserted during WAIT, late response ignored
    @(negedge clk);
    in_result = 32'h300; in_funct3 = 3'b010; in_is_load = 1; in_rd_addr = 12;
    in_reg_write = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in_is_load = 0;
    @(negedge clk);
    chk("rstw_req_valid", mem_req_valid, 1);
    mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rstw_in_ready", in_ready, 1);
    chk("rstw_req_valid_low", mem_req_valid, 0);
    chk("rstw_out_valid", out_valid, 0);
    chk("rstw_req_addr", mem_req_addr, 0);
    chk("rstw_misc", {out_err, mem_req_wen, mem_req_wmask, out_rd_addr, out_reg_write}, 0);
    chk("rstw_wb", out_wb_data, 0);
    @(posedge clk); #1;
    rst_n = 1;
    mem_resp_valid = 1; mem_resp_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_resp_valid = 0;
    ok = 1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || !in_ready || mem_req_valid) ok = 0;
    end
    chk("rstw_late_resp_ignored", ok, 1);

    // randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      ld = (kind < 5);
      st = (kind >= 4 && kind < 8);
      if (st && !ld) f3 = 3'($urandom_range(0, 2));
      else if (ld) begin
        case ($urandom_range(0, 9))
          0: f3 = 3'b011;
          1: f3 = 3'b110;
          2, 3: f3 = 3'b010;
          4, 5: f3 = 3'b000;
          6: f3 = 3'b100;
          7: f3 = 3'b001;
          default: f3 = 3'b101;
        endcase
      end else f3 = 3'($urandom);
      begin
        logic [31:0] res, wd, rdata;
        logic [4:0] rd;
        logic rw;
        int stall, lat, bp;
        res = $urandom; wd = $urandom; rdata = $urandom;
        rd = 5'($urandom); rw = 1'($urandom);
        stall = $urandom_range(0, 2); lat = $urandom_range(0, 3); bp = $urandom_range(0, 2);
        run_op(res, wd, rdata, f3, ld, st, rd, rw, stall, lat, bp, o);
        e = model(res, wd, rdata, f3, ld, st, rd, rw);
        cmp($sformatf("rnd%0d", i), o, e, bp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_25040109_lsu.md
Name: ysyx_25040109_lsu

Overview:
Load/store stage sitting directly downstream of the execute stage and upstream of writeback. It takes the execute result (effective address or ALU/CSR/link value), store data and funct3. Loads and stores run through a single-outstanding request/response memory port with byte-lane masking and load sign/zero extension; all other instructions pass through. Valid/ready handshakes are used on all three sides.

Parameters:
TIMEOUT_CYCLES, 255, cycles waited for mem_resp_valid before aborting with out_err; range 1..65535.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute stage holds a valid instruction
in_ready  out  1  LSU accepts; transfer when in_valid&&in_ready
in_result  in  32  execute result (address for load/store)
in_wdata  in  32  rs2 data for stores
in_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_is_load  in  1  opcode 0000011
in_is_store  in  1  opcode 0100011
in_rd_addr  in  5  destination register
in_reg_write  in  1  register write enable from execute
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_wen  out  1  1 store, 0 load
mem_req_addr  out  32  {in_result[31:2],2'b00}
mem_req_wdata  out  32  store data shifted to its lane
mem_req_wmask  out  4  byte strobes (0 for loads)
mem_resp_valid  in  1  response valid (read data or write ack)
mem_resp_rdata  in  32  read word
out_valid  out  1  result ready for writeback
out_ready  in  1  writeback accepts
out_wb_data  out  32  extended load data or passthrough result
out_rd_addr  out  5  registered rd
out_reg_write  out  1  registered write enable (0 for stores, 0 on error)
out_err  out  1  access fault: timeout (or misalignment, see option)

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1, mem_req_valid=0, out_valid=0, out_err=0, out_wb_data=0, out_rd_addr=0, out_reg_write=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0, timeout counter=0. Reset mid-transaction drops the transaction; late mem_resp_valid after reset is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On accept: if not load/store, register in_result/rd/reg_write, go DONE (1-cycle latency). If load/store, latch address, data, funct3, rd; go REQ with mem_req_valid=1 the next cycle.
- REQ: hold mem_req_* stable while mem_req_valid&&!mem_req_ready. On handshake go WAIT; clear the counter.
- WAIT: the counter increments each cycle. On mem_resp_valid, load: lane = addr[1:0]; B/BU select byte lane, H/HU select halfword addr[1]; sign- or zero-extend into out_wb_data; go DONE. Store: out_wb_data=0, out_reg_write=0, go DONE. If the counter reaches TIMEOUT_CYCLES-1 without a response: out_err=1, out_reg_write=0, go DONE. A response arriving in the same cycle as the terminal count wins (no error).
- Store lanes: SB wmask=1<<a[1:0], wdata={4{b}}; SH wmask=a[1]?1100:0011, wdata={2{h}}; SW wmask=1111.
- DONE: out_valid=1; outputs stable until out_ready. On handshake out_valid=0 and go IDLE; in_ready returns next cycle (no same-cycle re-accept; max one instruction in flight).
- in_ready=0 in REQ/WAIT/DONE. in_is_load&&in_is_store both set: treated as load.
- Unsupported funct3 on a load (011,110,111): no memory access; out_wb_data=0, out_reg_write=0, straight to DONE.
- Without the option, misaligned H/W access uses the word address with lanes as computed above; no error is raised.

Optional Feature:
LSU_MISALIGN_CHECK_EN: when defined, a load/store with H and addr[0]=1, or W and addr[1:0]!=0, issues no memory request and goes IDLE->DONE with out_err=1, out_reg_write=0, out_wb_data=in_result (faulting address). When undefined, out_err only reflects timeout and misaligned accesses proceed as described above.

Test Plan:
ALU passthrough: in_result=0x1234, is_load=0, rd=5, reg_write=1, out_ready=1 -> out_valid one cycle after accept, out_wb_data=0x1234, out_rd_addr=5, no mem_req_valid.
LB sign: addr 0x80000003, resp rdata 0x80FF7F01 -> mem_req_addr 0x80000000, wmask 0, out_wb_data 0xFFFFFF80; LBU same -> 0x00000080.
SH upper: addr 0x10000002, wdata 0x0000BEEF, mem_req_ready low for 3 cycles -> req fields stable, wmask 1100, wdata 0xBEEFBEEF, out_reg_write=0 after ack.
Timeout: TIMEOUT_CYCLES=4, load, no resp -> out_err=1 on the 4th cycle of WAIT, out_reg_write=0; a response on the terminal cycle gives out_err=0.
Backpressure and reset: out_ready=0 for 5 cycles in DONE -> outputs held, in_ready=0. Assert rst_n low during WAIT -> all outputs are reset values immediately; a later mem_resp_valid is ignored.
With LSU_MISALIGN_CHECK_EN: LW addr 0x102 -> no mem_req_valid, out_err=1, out_wb_data=0x102.
